instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_1000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the bubble instruction sent to decode.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- jump_flag_ex  in  1  redirect request from execute
- jump_address_ex  in  32  redirect target
- stall  in  1  decode cannot accept a new instruction this cycle
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched word
- instruction  out  32  instruction to decode, registered
- instruction_address  out  32  address of the instruction output
- instruction_valid  out  1  instruction output is a real fetched word
- pre_jump_flag_id  out  1  one-cycle flush pulse to decode

Function
REQ-004 SHALL implement a three-state FSM: FETCH, HOLD and DISCARD.
REQ-005 SHALL, in FETCH and DISCARD, drive imem_req=1 and keep imem_addr constant until imem_ack; in HOLD it SHALL drive imem_req=0.
REQ-006 SHALL always drive imem_addr[1:0]=0 and SHALL force bits [1:0] of jump_address_ex to 0 when loading the PC.
REQ-007 SHALL, on imem_ack in FETCH with stall=0 and jump_flag_ex=0, take these values at the next edge: instruction=imem_rdata, instruction_address=pc, instruction_valid=1, pc=pc+4. Latency from ack to output is one edge.
REQ-008 SHALL, on imem_ack in FETCH with stall=1, capture rdata and pc into a one-entry hold buffer, advance pc by 4, freeze all outputs and enter HOLD.
REQ-009 SHALL, in HOLD, present the held instruction on the first edge where stall=0, then return to FETCH.
REQ-010 SHALL, while stall=1 and no ack is present, keep instruction, instruction_address and instruction_valid unchanged.
REQ-011 SHALL give jump_flag_ex priority over stall and ack. At the next edge: pc=jump target, instruction=NOP_INSTR, instruction_valid=0, pre_jump_flag_id=1, and the hold buffer is emptied.
REQ-012 SHALL, when a jump arrives while a request is outstanding without ack in the same cycle, enter DISCARD. It SHALL keep the old request until ack, drop that returned data, then go to FETCH at the jump target.
REQ-013 SHALL, when a jump and ack coincide, drop the returned data and go directly to FETCH at the jump target.
REQ-014 SHALL, on a second jump during DISCARD, update pc to the newest target and remain in DISCARD.
REQ-015 SHALL keep pre_jump_flag_id high for exactly one cycle per jump; back-to-back jumps give back-to-back pulses.
REQ-016 SHALL wrap pc from 32'hFFFF_FFFC to 32'h0000_0000 modulo 2^32.

Reset
REQ-017 SHALL, on rst=1 at a rising edge, set: pc=RESET_PC, state=FETCH, instruction=NOP_INSTR, instruction_address=0, instruction_valid=0, pre_jump_flag_id=0, hold buffer empty, and imem_req=0 for that cycle.
REQ-018 SHALL, on reset during an outstanding request, abandon the request and ignore any late ack received in the cycle reset is asserted.
REQ-019 SHALL issue the first request at RESET_PC in the cycle after rst deasserts.

Configuration
REQ-020 SHALL, with IF_PERF_COUNTERS_EN defined, add 32-bit outputs fetch_count and discard_count. Both reset to 0 and wrap silently:
- fetch_count increments on each ack delivered or held.
- discard_count increments on each ack dropped under REQ-012 or REQ-013.
REQ-021 SHALL, without IF_PERF_COUNTERS_EN, omit those ports and counters, with all other behaviour identical.

Structure
REQ-022 SHALL take NOP_INSTR, the RESET_PC default and the fetch_state_t enum (FETCH/HOLD/DISCARD) from the shared package cpu_pkg.
REQ-023 SHALL place the one-entry hold buffer in sub-module instruction_fetch_hold (ports: load, clear, data/address in and out, full).

Verification
REQ-024 Reset release, imem_ack one cycle after each request: imem_addr sequence 0x1000, 0x1004, 0x1008; instruction_valid=1 from the edge after the first ack.
REQ-025 stall=1 for 3 cycles, ack arriving during the stall: outputs frozen, imem_req=0 in HOLD; held word appears on the edge after stall falls; no duplicate or lost address.
REQ-026 jump_flag_ex with target 0x2002, ack arriving 2 cycles later: pre_jump_flag_id pulses once, instruction=0x00000013; old data dropped; next imem_addr=0x2000.
REQ-027 Jump and ack in the same cycle, target 0x3000: returned word not delivered; FSM stays out of DISCARD; next imem_addr=0x3000.
REQ-028 pc=0xFFFF_FFFC fetched: next imem_addr=0x0000_0000.
REQ-029 rst asserted mid-request with a late ack: outputs return to reset values; first request after release is at 0x1000; with IF_PERF_COUNTERS_EN, both counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch constants, bubble instruction and fetch FSM state type
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_hold.sv
// instruction_fetch_hold: one-entry buffer parking a fetched word while decode stalls
module instruction_fetch_hold
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] data_in,
  input  logic [XLEN-1:0] addr_in,
  output logic [XLEN-1:0] data_out,
  output logic [XLEN-1:0] addr_out,
  output logic            full
);
  logic [XLEN-1:0] data_q, data_d, addr_q, addr_d;
  logic full_q, full_d;
  always_comb begin
    data_d = load ? data_in : data_q;
    addr_d = load ? addr_in : addr_q;
    full_d = load | (full_q & ~clear);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      addr_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
      full_q <= full_d;
    end
  end
  assign data_out = data_q;
  assign addr_out = addr_q;
  assign full = full_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: FETCH/HOLD/DISCARD fetch unit with jump flush; IF_PERF_COUNTERS_EN adds fetch/discard counters
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_ex,
  input  logic [31:0] jump_address_ex,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instruction_address,
  output logic        instruction_valid,
  output logic        pre_jump_flag_id
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] discard_count
`endif
);
  import cpu_pkg::*;
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, disc_addr_q, disc_addr_d;
  logic [31:0] instr_q, instr_d, instr_addr_q, instr_addr_d;
  logic valid_q, valid_d, flush_q, flush_d;
  logic hold_load, hold_clear, hold_full;
  logic [31:0] hold_data, hold_addr;
  instruction_fetch_hold u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .clear    (hold_clear),
    .data_in  (imem_rdata),
    .addr_in  (pc_q),
    .data_out (hold_data),
    .addr_out (hold_addr),
    .full     (hold_full)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    disc_addr_d = disc_addr_q;
    instr_d = instr_q;
    instr_addr_d = instr_addr_q;
    valid_d = valid_q;
    flush_d = jump_flag_ex;
    hold_load = 1'b0;
    hold_clear = 1'b0;
    if (jump_flag_ex) begin
      pc_d = {jump_address_ex[31:2], 2'b00};
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      hold_clear = 1'b1;
      state_d = (state_q == HOLD || imem_ack) ? FETCH : DISCARD;
      if (state_q == FETCH) disc_addr_d = pc_q;
    end else if (state_q == HOLD) begin
      if (!stall && hold_full) begin
        instr_d = hold_data;
        instr_addr_d = hold_addr;
        valid_d = 1'b1;
        hold_clear = 1'b1;
        state_d = FETCH;
      end
    end else if (imem_ack) begin
      if (state_q == DISCARD) begin
        state_d = FETCH;
      end else begin
        pc_d = pc_q + 32'd4;
        if (stall) begin
          hold_load = 1'b1;
          state_d = HOLD;
        end else begin
          instr_d = imem_rdata;
          instr_addr_d = pc_q;
          valid_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= {RESET_PC[31:2], 2'b00};
      disc_addr_q <= '0;
      instr_q <= NOP_INSTR;
      instr_addr_q <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      disc_addr_q <= disc_addr_d;
      instr_q <= instr_d;
      instr_addr_q <= instr_addr_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
    end
  end
  assign imem_req = !rst && state_q != HOLD;
  assign imem_addr = state_q == DISCARD ? disc_addr_q : pc_q;
  assign instruction = instr_q;
  assign instruction_address = instr_addr_q;
  assign instruction_valid = valid_q;
  assign pre_jump_flag_id = flush_q;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q, fetch_count_d, discard_count_q, discard_count_d;
  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, imem_ack && state_q == FETCH && !jump_flag_ex};
    discard_count_d = discard_count_q + {31'd0, imem_ack && (state_q == DISCARD || (state_q == FETCH && jump_flag_ex))};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      discard_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      discard_count_q <= discard_count_d;
    end
  end
  assign fetch_count = fetch_count_q;
  assign discard_count = discard_count_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of instruction_fetch against a transaction-level model
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, jump_flag_ex, stall, imem_ack, imem_req;
  logic [31:0] jump_address_ex, imem_addr, imem_rdata, instruction, instruction_address;
  logic instruction_valid, pre_jump_flag_id;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_count, discard_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc, stale_addr, o_i, o_a, fc, dc;
  logic stale, o_v, o_f;
  logic [63:0] held[$];
  instruction_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .jump_flag_ex        (jump_flag_ex),
    .jump_address_ex     (jump_address_ex),
    .stall               (stall),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_ack            (imem_ack),
    .imem_rdata          (imem_rdata),
    .instruction         (instruction),
    .instruction_address (instruction_address),
    .instruction_valid   (instruction_valid),
    .pre_jump_flag_id    (pre_jump_flag_id)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .fetch_count         (fetch_count),
    .discard_count       (discard_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ (a + 32'hC0DE_0000);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic j, input logic [31:0] t, input logic s, input logic a);
    logic exp_req, a_eff;
    logic [31:0] exp_addr, rd;
    exp_req = !r && held.size() == 0;
    exp_addr = stale ? stale_addr : m_pc;
    a_eff = a && (exp_req || r);
    rd = mem(exp_addr);
    rst = r;
    jump_flag_ex = j;
    jump_address_ex = t;
    stall = s;
    imem_ack = a_eff;
    imem_rdata = rd;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    @(posedge clk);
    if (r) begin
      m_pc = RST_PC; stale = 0; held.delete();
      o_i = NOP; o_a = 0; o_v = 0; o_f = 0; fc = 0; dc = 0;
    end else begin
      o_f = j;
      if (j) begin
        if (held.size() == 0) begin
          if (a_eff) begin dc++; stale = 0; end
          else begin if (!stale) stale_addr = m_pc; stale = 1; end
        end
        held.delete();
        m_pc = t & ~32'h3;
        o_i = NOP;
        o_v = 0;
      end else if (held.size() != 0) begin
        if (!s) begin {o_i, o_a} = held.pop_front(); o_v = 1; end
      end else if (a_eff) begin
        if (stale) begin stale = 0; dc++; end
        else begin
          fc++;
          if (s) held.push_back({rd, m_pc});
          else begin o_i = rd; o_a = m_pc; o_v = 1; end
          m_pc = m_pc + 32'd4;
        end
      end
    end
    #1;
    chk("instruction", instruction, o_i);
    chk("instruction_address", instruction_address, o_a);
    chk("instruction_valid", {31'd0, instruction_valid}, {31'd0, o_v});
    chk("pre_jump_flag_id", {31'd0, pre_jump_flag_id}, {31'd0, o_f});
`ifdef IF_PERF_COUNTERS_EN
    chk("fetch_count", fetch_count, fc);
    chk("discard_count", discard_count, dc);
`endif
    @(negedge clk);
  endtask
  initial begin
    m_pc = RST_PC; stale = 0; stale_addr = 0;
    o_i = NOP; o_a = 0; o_v = 0; o_f = 0; fc = 0; dc = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("reset_instruction", instruction, NOP);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("first_valid", {31'd0, instruction_valid}, 32'd1);
    chk("first_addr", instruction_address, 32'h1000);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("third_req_addr", imem_addr, 32'h1008);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("hold_frozen_addr", instruction_address, 32'h1004);
    step(0, 0, 0, 0, 0);
    chk("held_delivered", instruction_address, 32'h1008);
    step(0, 1, 32'h2002, 0, 0);
    chk("jump_nop", instruction, NOP);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("jump_target_addr", imem_addr, 32'h2000);
    step(0, 1, 32'h3000, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("jump_ack_addr", imem_addr, 32'h3000);
    step(0, 1, 32'h4000, 0, 0);
    step(0, 1, 32'h5004, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("post_reset_addr", imem_addr, 32'h1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
